// File: rtl/neural_soc_sysid_pkg.sv
// Shared types for the sysid checker: FSM state encoding and the
// error codes reported on error_code.
package neural_soc_sysid_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ID,
      S_WT_ID,
      S_RD_TS,
      S_WT_TS,
      S_CHECK,
      S_FIN
   } state_t;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_ID   = 2'd1;
   localparam logic [1:0] ERR_TS   = 2'd2;
   localparam logic [1:0] ERR_TMO  = 2'd3;

endpackage

// File: rtl/neural_soc_sysid_checker.sv
// Reads the sysid slave over Avalon-MM and compares ID/timestamp words.
// Define NEURAL_SOC_SYSID_TS_CHECK_EN to include the timestamp read/compare.
module neural_soc_sysid_checker
   import neural_soc_sysid_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = 32'd0,
   parameter logic [31:0] EXPECTED_TS    = 32'd1480974486,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned MAX_RETRIES    = 3
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic        avm_readdatavalid,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic [1:0]  error_code
);

`ifdef NEURAL_SOC_SYSID_TS_CHECK_EN
   localparam bit TS_CHK_EN = 1'b1;
`else
   localparam bit TS_CHK_EN = 1'b0;
`endif

   localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
   localparam int RW = $clog2(MAX_RETRIES + 2);
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES);
   localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRIES);

   state_t          state_q, state_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [RW-1:0]   rty_q, rty_d;
   logic [31:0]     id_q, id_d;
   logic [31:0]     ts_q, ts_d;
   logic [1:0]      err_q, err_d;
   logic            pass_q, pass_d;

   logic            rd_st, wt_st, ts_word;
   logic            acc, got, id_mis, ts_mis;
   logic [1:0]      chk_err;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         tmo_q   <= '0;
         rty_q   <= '0;
         id_q    <= '0;
         ts_q    <= '0;
         err_q   <= ERR_NONE;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         rty_q   <= rty_d;
         id_q    <= id_d;
         ts_q    <= ts_d;
         err_q   <= err_d;
         pass_q  <= pass_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      rty_d   = rty_q;
      id_d    = id_q;
      ts_d    = ts_q;
      err_d   = err_q;
      pass_d  = pass_q;

      rd_st   = (state_q == S_RD_ID) || (state_q == S_RD_TS);
      wt_st   = (state_q == S_WT_ID) || (state_q == S_WT_TS);
      ts_word = (state_q == S_RD_TS) || (state_q == S_WT_TS);
      acc     = rd_st && !avm_waitrequest;
      // zero-latency slaves return data in the accept cycle itself
      got     = (acc || wt_st) && avm_readdatavalid;
      id_mis  = (id_q != EXPECTED_ID);
      ts_mis  = TS_CHK_EN && (ts_q != EXPECTED_TS);
      chk_err = id_mis ? ERR_ID : (ts_mis ? ERR_TS : ERR_NONE);

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RD_ID;
               tmo_d   = TMO_LOAD;
               rty_d   = '0;
               err_d   = ERR_NONE;
               pass_d  = 1'b0;
            end
         end
         S_RD_ID, S_WT_ID, S_RD_TS, S_WT_TS: begin
            if (got) begin
               rty_d = '0;
               tmo_d = TMO_LOAD;
`ifdef NEURAL_SOC_SYSID_TS_CHECK_EN
               if (ts_word) begin
                  ts_d    = avm_readdata;
                  state_d = S_CHECK;
               end else begin
                  id_d    = avm_readdata;
                  state_d = S_RD_TS;
               end
`else
               id_d    = avm_readdata;
               state_d = S_CHECK;
`endif
            end else if (tmo_q == '0) begin
               if (rty_q < RTY_MAX) begin
                  rty_d   = rty_q + RW'(1);
                  tmo_d   = TMO_LOAD;
                  state_d = ts_word ? S_RD_TS : S_RD_ID;
               end else begin
                  err_d   = ERR_TMO;
                  pass_d  = 1'b0;
                  state_d = S_FIN;
               end
            end else begin
               tmo_d = tmo_q - TW'(1);
               if (acc) state_d = ts_word ? S_WT_TS : S_WT_ID;
            end
         end
         S_CHECK: begin
            // result lands with the FIN entry so it is valid alongside done
            err_d   = chk_err;
            pass_d  = (chk_err == ERR_NONE);
            state_d = S_FIN;
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign avm_read    = rd_st;
   assign avm_address = (state_q == S_RD_TS);
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_FIN);
   assign pass        = pass_q;
   assign id_value    = id_q;
   assign ts_value    = ts_q;
   assign error_code  = err_q;

endmodule

// File: tb/tb_neural_soc_sysid_checker.sv
// Randomized scoreboard bench for neural_soc_sysid_checker with an
// Avalon-MM sysid slave model of configurable stall and read latency.
module tb_neural_soc_sysid_checker;

   localparam logic [31:0] EXP_ID = 32'd0;
   localparam logic [31:0] EXP_TS = 32'd1480974486;
   localparam int          T_ATT  = 256;
   localparam int          N_ATT  = 4;
`ifdef NEURAL_SOC_SYSID_TS_CHECK_EN
   localparam bit TS_EN = 1'b1;
`else
   localparam bit TS_EN = 1'b0;
`endif

   logic        clock;
   logic        reset_n;
   logic        start;
   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic        avm_readdatavalid;
   logic [31:0] avm_readdata;
   logic        busy, done, pass;
   logic [31:0] id_value, ts_value;
   logic [1:0]  error_code;

   neural_soc_sysid_checker #(
      .EXPECTED_ID(EXP_ID),
      .EXPECTED_TS(EXP_TS),
      .TIMEOUT_CYCLES(255),
      .MAX_RETRIES(3)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .start(start),
      .avm_address(avm_address),
      .avm_read(avm_read),
      .avm_waitrequest(avm_waitrequest),
      .avm_readdatavalid(avm_readdatavalid),
      .avm_readdata(avm_readdata),
      .busy(busy),
      .done(done),
      .pass(pass),
      .id_value(id_value),
      .ts_value(ts_value),
      .error_code(error_code)
   );

   typedef struct {
      logic [1:0]  err;
      logic        pass;
      logic [31:0] id;
      logic [31:0] ts;
      int          cyc;
      int          acc0;
      int          acc1;
   } exp_t;

   exp_t        sbq[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [31:0] s_data[2];
   int          s_lat[2];
   int          s_stall[2];
   int          pend = 0;
   int          pend_a = 0;
   logic [31:0] m_id = '0;
   logic [31:0] m_ts = '0;
   int          acc[2];
   logic        prev_stall = 1'b0;
   logic        prev_addr = 1'b0;
   exp_t        me;

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " avm_read"}, 32'(avm_read), 0);
      chk({tag, " avm_address"}, 32'(avm_address), 0);
      chk({tag, " busy"}, 32'(busy), 0);
      chk({tag, " done"}, 32'(done), 0);
      chk({tag, " pass"}, 32'(pass), 0);
      chk({tag, " error_code"}, 32'(error_code), 0);
      chk({tag, " id_value"}, id_value, 0);
      chk({tag, " ts_value"}, ts_value, 0);
   endtask

   // slave: responds after each edge, stalls and delays per address config
   initial begin
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
      forever begin
         @(posedge clock);
         #1;
         avm_readdatavalid = 1'b0;
         avm_readdata      = $urandom;
         avm_waitrequest   = 1'b0;
         if (!reset_n) pend = 0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               avm_readdatavalid = 1'b1;
               avm_readdata      = s_data[pend_a];
            end
         end
         if (reset_n && avm_read) begin
            if (s_stall[avm_address] > 0) begin
               avm_waitrequest = 1'b1;
               s_stall[avm_address]--;
            end else if (s_lat[avm_address] == 0) begin
               avm_readdatavalid = 1'b1;
               avm_readdata      = s_data[avm_address];
            end else if (s_lat[avm_address] > 0) begin
               pend   = s_lat[avm_address];
               pend_a = int'(avm_address);
            end
         end
      end
   end

   // monitor: bus protocol checks and scoreboard pop on every done pulse
   always @(negedge clock) begin
      if (!reset_n) begin
         acc[0]     = 0;
         acc[1]     = 0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall read held", 32'(avm_read), 1);
            chk("stall addr held", 32'(avm_address), 32'(prev_addr));
         end
         prev_stall = avm_read && avm_waitrequest;
         prev_addr  = avm_address;
         if (avm_read && !avm_waitrequest) acc[avm_address]++;
         if (!TS_EN && avm_read) chk("no ts access", 32'(avm_address), 0);
         if (done) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious done: got 1 expected 0");
            end else begin
               me = sbq.pop_front();
               chk("done latency", cyc, me.cyc);
               chk("error_code", 32'(error_code), 32'(me.err));
               chk("pass", 32'(pass), 32'(me.pass));
               chk("id_value", id_value, me.id);
               chk("ts_value", ts_value, me.ts);
               chk("busy at done", 32'(busy), 1);
               chk("reads addr0", acc[0], me.acc0);
               chk("reads addr1", acc[1], me.acc1);
            end
            acc[0] = 0;
            acc[1] = 0;
         end
      end
   end

   task automatic recover();
      @(negedge clock);
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      sbq.delete();
      reset_n = 1'b1;
      m_id = '0;
      m_ts = '0;
   endtask

   task automatic run_txn(input logic [31:0] d0, input logic [31:0] d1,
                          input int l0, input int l1, input int s0,
                          input int s1, input bit dbl);
      exp_t e;
      int   lat;
      e.acc0 = 1;
      e.acc1 = 0;
      if (l0 < 0) begin
         lat    = N_ATT * T_ATT;
         e.err  = 2'd3;
         e.acc0 = N_ATT;
      end else begin
         lat  = s0 + 1 + l0;
         m_id = d0;
         if (TS_EN && l1 < 0) begin
            lat    = lat + N_ATT * T_ATT;
            e.err  = 2'd3;
            e.acc1 = N_ATT;
         end else begin
            if (TS_EN) begin
               lat    = lat + s1 + 1 + l1;
               m_ts   = d1;
               e.acc1 = 1;
            end
            lat = lat + 1;
            if (d0 != EXP_ID) e.err = 2'd1;
            else if (TS_EN && d1 != EXP_TS) e.err = 2'd2;
            else e.err = 2'd0;
         end
      end
      e.pass = (e.err == 2'd0);
      e.id   = m_id;
      e.ts   = m_ts;
      s_data[0]  = d0;
      s_data[1]  = d1;
      s_lat[0]   = l0;
      s_lat[1]   = l1;
      s_stall[0] = s0;
      s_stall[1] = s1;
      @(negedge clock);
      e.cyc = cyc + 1 + lat;
      sbq.push_back(e);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      if (dbl) begin
         @(negedge clock);
         start = 1'b1;
         @(negedge clock);
         start = 1'b0;
      end
      for (int i = 0; i < 4000 && sbq.size() != 0; i++) @(negedge clock);
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL done wait: got none expected done by cycle %0d",
                  e.cyc);
         recover();
      end
      repeat (2) @(negedge clock);
   endtask

   task automatic reset_mid();
      bit tgt;
      bit found;
      tgt        = TS_EN;
      found      = 1'b0;
      s_data[0]  = EXP_ID;
      s_data[1]  = EXP_TS;
      s_lat[0]   = 1;
      s_lat[1]   = 1;
      s_lat[tgt] = 6;
      s_stall[0] = 0;
      s_stall[1] = 0;
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (avm_read && avm_address == tgt && !avm_waitrequest) found = 1'b1;
         else @(negedge clock);
      end
      chk("reach wait state", 32'(found), 1);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      chk_zero("mid reset");
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      m_id = '0;
      m_ts = '0;
      repeat (10) @(negedge clock);
   endtask

   initial begin
      reset_n    = 1'b0;
      start      = 1'b0;
      s_data[0]  = '0;
      s_data[1]  = '0;
      s_lat[0]   = 1;
      s_lat[1]   = 1;
      s_stall[0] = 0;
      s_stall[1] = 0;
      repeat (3) @(negedge clock);
      chk_zero("reset");
      reset_n = 1'b1;
      @(negedge clock);
      chk("idle busy", 32'(busy), 0);

      run_txn(EXP_ID, EXP_TS, 1, 1, 0, 0, 1'b0);
      run_txn(32'h1, EXP_TS, 1, 1, 0, 0, 1'b0);
      run_txn(EXP_ID, EXP_TS, 1, 1, 10, 0, 1'b0);
      run_txn(EXP_ID, EXP_TS, 0, 0, 0, 0, 1'b0);
      run_txn(EXP_ID, 32'hdead_beef, 1, 2, 0, 3, 1'b0);
      run_txn(32'h5, 32'h7, -1, 1, 2, 0, 1'b0);
      run_txn(EXP_ID, 32'h9, 2, -1, 0, 1, 1'b0);
      run_txn(EXP_ID, EXP_TS, 0, 0, 0, 0, 1'b1);
      reset_mid();
      run_txn(EXP_ID, EXP_TS, 1, 1, 0, 0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         logic [31:0] d0, d1;
         int          l0, l1, s0, s1;
         bit          dbl;
         d0  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : EXP_ID;
         d1  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : EXP_TS;
         l0  = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 3));
         l1  = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 3));
         s0  = ($urandom_range(0, 7) == 0) ? 12 : int'($urandom_range(0, 4));
         s1  = int'($urandom_range(0, 4));
         dbl = 1'($urandom_range(0, 1));
         run_txn(d0, d1, l0, l1, s0, s1, dbl);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/neural_soc_sysid_checker.md
NEURAL_SOC_SYSID_CHECKER -- requirements
Module: neural_soc_sysid_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'd0, the expected system ID word at address 0.
REQ-002 SHALL have parameter EXPECTED_TS, default 32'd1480974486, the expected timestamp word at address 1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum number of cycles allowed per read transaction.
REQ-004 SHALL have parameter MAX_RETRIES, default 3, the number of retries per word after a timeout.
REQ-005 SHALL have port clock, input, 1, the single clock for all logic.
REQ-006 SHALL have port reset_n, input, 1, an asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, a single-cycle request to begin a check.
REQ-008 SHALL have port avm_address, output, 1, the word select: 0 = ID, 1 = timestamp.
REQ-009 SHALL have port avm_read, output, 1, the Avalon-MM read request.
REQ-010 SHALL have port avm_waitrequest, input, 1, the slave stall signal.
REQ-011 SHALL have port avm_readdatavalid, input, 1, which qualifies avm_readdata.
REQ-012 SHALL have port avm_readdata, input, 32, the read data from the sysid slave.
REQ-013 SHALL have ports busy, done, and pass, outputs, 1 each: check in progress, one-cycle completion pulse, and sticky result.
REQ-014 SHALL have ports id_value and ts_value, outputs, 32 each, holding the captured words.
REQ-015 SHALL have port error_code, output, 2, where 0 = none, 1 = ID mismatch, 2 = timestamp mismatch, and 3 = timeout.

Function
REQ-016 SHALL implement the FSM states IDLE, RD_ID, WT_ID, RD_TS, WT_TS, CHECK, and FIN.
REQ-017 SHALL go from IDLE to RD_ID on start=1, clearing pass, error_code, and the retry count; start SHALL be ignored in any state other than IDLE.
REQ-018 SHALL, in RD_ID and RD_TS, hold avm_read=1 with avm_address equal to 0 or 1 respectively and stable until a cycle with avm_waitrequest=0, then go to WT_ID or WT_TS.
REQ-019 SHALL, in WT_ID and WT_TS, capture avm_readdata into id_value or ts_value on avm_readdatavalid=1; avm_read SHALL be 0 in these states.
REQ-020 SHALL accept avm_readdatavalid in the same cycle as the accepting edge (zero read latency) and advance directly without entering a WT state.
REQ-021 SHALL reload the timeout counter on every RD entry and decrement it each cycle in RD/WT states; reaching 0 SHALL count as a timeout.
REQ-022 SHALL, on timeout with retries below MAX_RETRIES, increment the retry count and re-enter the same RD state; otherwise it SHALL set error_code=3 and go to FIN.
REQ-023 SHALL reset the retry count per word when that word is captured.
REQ-024 SHALL, in CHECK, set error_code=1 if the ID mismatches, else 2 if the timestamp mismatches, else 0; ID mismatch takes priority.
REQ-025 SHALL, in FIN, pulse done=1 for exactly one cycle, set pass=(error_code==0), and return to IDLE.
REQ-026 SHALL hold busy=1 in every state except IDLE.
REQ-027 SHALL have a latency of 5 cycles from start to done when waitrequest=0 and readdatavalid arrives one cycle after the accept.
REQ-028 SHALL ignore avm_readdatavalid while in IDLE, CHECK, or FIN.

Reset
REQ-029 SHALL, on reset_n=0, immediately force state IDLE, avm_read=0, avm_address=0, busy=0, done=0, pass=0, error_code=0, id_value=0, ts_value=0, and clear both counters.
REQ-030 SHALL abandon a transaction when reset asserts mid-transaction; no done pulse SHALL be produced for it.

Configuration
REQ-031 SHALL compile in the timestamp read/compare when macro NEURAL_SOC_SYSID_TS_CHECK_EN is defined.
REQ-032 SHALL, when the macro is undefined, go from WT_ID directly to CHECK, never issue address 1, hold ts_value at 0, and never produce error_code 2; latency SHALL drop to 3 cycles.

Structure
REQ-033 SHALL place the state enum and error-code constants in the shared package neural_soc_sysid_pkg.
REQ-034 SHALL be a single flat module with no sub-modules; the timeout/retry counter is inline logic.

Verification
REQ-035 Nominal: start, slave returns 0 and 1480974486 with zero waitrequest -> done after 5 cycles, pass=1, error_code=0.
REQ-036 ID mismatch: slave returns 32'h1 at address 0 -> pass=0, error_code=1, id_value=1.
REQ-037 Waitrequest stall: waitrequest=1 for 10 cycles on the ID read -> address and read stay stable, then pass=1.
REQ-038 Timeout: readdatavalid never asserted -> 4 read attempts at address 0, then error_code=3 and done after about 4*256 cycles.
REQ-039 Reset mid-operation: reset_n low during WT_TS -> all outputs 0 and no done pulse; a following start completes normally.
REQ-040 Macro off: nominal stimulus -> no address 1 access, done after 3 cycles, ts_value=0, pass=1.
